// File: rtl/parallel2serial_10i_pkg.sv
// Shared definitions for the frame serializer and its serial weight loader
// counterpart: FSM state encodings and default frame geometry.
package parallel2serial_10i_pkg;

    // Serializer FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } p2s_state_t;

    // Default frame geometry: ten FP32 words, 4-bit word index.
    localparam int P2S_DATA_WIDTH = 32;
    localparam int P2S_NUM_WORDS  = 10;
    localparam int P2S_CNT_W      = 4;

endpackage : parallel2serial_10i_pkg

// File: rtl/parallel2serial_10i_if.sv
// Parallel-in / serial-out bus of the frame serializer.
// master: the serializer itself (drives in_ready and the serial side).
// slave : the environment (drives the frame and out_ready).
interface parallel2serial_10i_if
    import parallel2serial_10i_pkg::*;
#(
    parameter int DATA_WIDTH = P2S_DATA_WIDTH,
    parameter int NUM_WORDS  = P2S_NUM_WORDS,
    parameter int CNT_W      = P2S_CNT_W
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH*NUM_WORDS-1:0] in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out;
    logic [CNT_W-1:0]                out_idx;
    logic                            out_last;
    logic                            busy;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out, out_idx, out_last, busy
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out, out_idx, out_last, busy
    );

endinterface : parallel2serial_10i_if

// File: rtl/parallel2serial_10i_word_mux.sv
// Combinational word select: picks word i_idx out of a packed frame.
// Out-of-range indices yield zero so the select never reads past the frame.
module parallel2serial_10i_word_mux
    import parallel2serial_10i_pkg::*;
#(
    parameter int DATA_WIDTH = P2S_DATA_WIDTH,
    parameter int NUM_WORDS  = P2S_NUM_WORDS,
    parameter int CNT_W      = P2S_CNT_W
) (
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] i_frame,
    input  logic [CNT_W-1:0]                i_idx,
    output logic [DATA_WIDTH-1:0]           o_word
);

    logic [DATA_WIDTH-1:0] w_words [NUM_WORDS];

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_split
        assign w_words[gi] = i_frame[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Select the indexed word; guard the unused index encodes.
    always_comb begin
        o_word = '0;
        if (int'(i_idx) < NUM_WORDS) begin
            o_word = w_words[i_idx];
        end
    end

endmodule : parallel2serial_10i_word_mux

// File: rtl/parallel2serial_10i.sv
// Frame serializer: captures NUM_WORDS parallel words in one handshake and
// streams them out one word per accepted beat, index 0 first.
// Optional macro P2S_BACK2BACK_EN: accept the next frame on the last beat of
// the current one, removing the idle bubble between frames.
module parallel2serial_10i
    import parallel2serial_10i_pkg::*;
#(
    parameter int DATA_WIDTH = P2S_DATA_WIDTH,
    parameter int NUM_WORDS  = P2S_NUM_WORDS,
    parameter int CNT_W      = P2S_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    parallel2serial_10i_if.master  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    p2s_state_t                      r_state;
    logic [CNT_W-1:0]                r_idx;
    logic [DATA_WIDTH*NUM_WORDS-1:0] r_frame;
    logic [DATA_WIDTH-1:0]           r_out;

    p2s_state_t                      w_state_next;
    logic [CNT_W-1:0]                w_idx_next;
    logic [DATA_WIDTH*NUM_WORDS-1:0] w_frame_next;
    logic [DATA_WIDTH-1:0]           w_word_next;

    logic w_shift;
    logic w_last;
    logic w_beat;
    logic w_idx_bad;
    logic w_in_ready;
    logic w_capture;

    assign w_shift   = (r_state == ST_SHIFT);
    assign w_last    = w_shift && (r_idx == LAST_IDX);
    // out_valid equals SHIFT, so a beat is simply SHIFT with out_ready.
    assign w_beat    = w_shift && bus.out_ready;
    assign w_idx_bad = (r_idx > LAST_IDX);

`ifdef P2S_BACK2BACK_EN
    assign w_in_ready = !w_shift || (w_last && bus.out_ready);
`else
    assign w_in_ready = !w_shift;
`endif

    assign w_capture = w_in_ready && bus.in_valid;

    // The serial word is registered from the next frame/index so it stays
    // stable under backpressure and holds its last value once idle.
    parallel2serial_10i_word_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .CNT_W      (CNT_W)
    ) u_word_mux (
        .i_frame (w_frame_next),
        .i_idx   (w_idx_next),
        .o_word  (w_word_next)
    );

    // State register plus counter, frame and output word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_frame <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_frame <= w_frame_next;
            if (w_state_next == ST_SHIFT) begin
                r_out <= w_word_next;
            end
        end
    end

    // Next-state logic: capture, advance on beats, return to IDLE after the last word.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_frame_next = r_frame;
        case (r_state)
            ST_IDLE: begin
                w_idx_next = '0;
                if (w_capture) begin
                    w_frame_next = bus.in_data;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_idx_bad) begin
                    // Unreachable index encode: recover to a clean IDLE.
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else if (w_beat) begin
                    if (w_last) begin
                        w_idx_next = '0;
                        if (w_capture) begin
                            w_frame_next = bus.in_data;
                            w_state_next = ST_SHIFT;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // Output decode from the current state and registers.
    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_shift;
        bus.busy      = w_shift;
        bus.out       = r_out;
        bus.out_idx   = r_idx;
        bus.out_last  = w_last;
    end

endmodule : parallel2serial_10i

// File: tb/tb_parallel2serial_10i.sv
// Self-checking bench for parallel2serial_10i: a queue-based model of the
// serial stream checked every cycle, plus directed literal expectations.
module tb_parallel2serial_10i;
    localparam int DW = 32;
    localparam int NW = 10;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parallel2serial_10i_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_W(CW)) bus();

    parallel2serial_10i #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of words still to emit
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_hold = '0;

    function automatic logic m_ready();
`ifdef P2S_BACK2BACK_EN
        return (m_q.size() == 0) || (m_q.size() == 1 && bus.out_ready === 1'b1);
`else
        return (m_q.size() == 0);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic rdy;
        if (rst) begin
            m_q.delete();
            m_hold = '0;
        end else begin
            rdy = m_ready();
            if (m_q.size() > 0 && bus.out_ready === 1'b1) void'(m_q.pop_front());
            if (rdy && bus.in_valid === 1'b1)
                for (int k = 0; k < NW; k++) m_q.push_back(bus.in_data[k*DW +: DW]);
            if (m_q.size() > 0) m_hold = m_q[0];
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",  bus.in_ready,  m_ready());
        chk("out_valid", bus.out_valid, m_q.size() > 0);
        chk("busy",      bus.busy,      m_q.size() > 0);
        chk("out_last",  bus.out_last,  m_q.size() == 1);
        chk("out",       bus.out,       m_hold);
        if (m_q.size() > 0) chk("out_idx", bus.out_idx, NW - m_q.size());
        else                chk("out_idx_idle", bus.out_idx, 0);
    end

    // Serial loader stand-in: records each beat by index; one line per beat.
    logic [DW-1:0] loader [NW];
    logic [DW-1:0] beats[$];
    always @(posedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (bus.out_idx < NW) loader[bus.out_idx] = bus.out;
            beats.push_back(bus.out);
            $display("[TB] beat idx=%0d word=%08h last=%0b", bus.out_idx, bus.out, bus.out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int k = 0; k < NW; k++) bus.in_data[k*DW +: DW] = base + step * k;
    endtask

    logic [DW-1:0] fp_tab [NW];
    int first_cyc, last_cyc, seen, cyc;

    initial begin
        fp_tab[0] = 32'h3F800000; fp_tab[1] = 32'h40000000; fp_tab[2] = 32'h40400000;
        fp_tab[3] = 32'h40800000; fp_tab[4] = 32'h40A00000; fp_tab[5] = 32'h40C00000;
        fp_tab[6] = 32'h40E00000; fp_tab[7] = 32'h41000000; fp_tab[8] = 32'h41100000;
        fp_tab[9] = 32'h41200000;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_busy", bus.busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single frame, out_ready held high
        beats.delete();
        set_frame(32'h3F800000, 32'd1);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("f1_first_valid", bus.out_valid, 1);
        chk("f1_first_word", bus.out, 32'h3F800000);
        chk("f1_first_idx", bus.out_idx, 0);
        chk("f1_first_notlast", bus.out_last, 0);
        repeat (9) tick();
        chk("f1_tenth_word", bus.out, 32'h3F800009);
        chk("f1_tenth_last", bus.out_last, 1);
        tick();
        chk("f1_busy_falls", bus.busy, 0);
        chk("f1_out_held", bus.out, 32'h3F800009);
        chk("f1_beat_count", beats.size(), NW);
        for (int k = 0; k < NW && k < beats.size(); k++)
            chk("f1_order", beats[k], 32'h3F800000 + k);
        tick();

        // Backpressure at idx 5, plus an ignored in_valid pulse mid-frame
        beats.delete();
        set_frame(32'hA5000000, 32'h111);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("bp_idx5", bus.out_idx, 5);
        bus.out_ready = 1'b0;
        set_frame(32'hDEAD0000, 32'd7);
        bus.in_valid = 1'b1;
        chk("bp_in_ready_low", bus.in_ready, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            bus.in_valid = 1'b0;
            chk("bp_hold_word", bus.out, 32'hA5000555);
            chk("bp_hold_idx", bus.out_idx, 5);
        end
        bus.out_ready = 1'b1;
        repeat (5) tick();
        chk("bp_done", bus.out_valid, 0);
        chk("bp_beat_count", beats.size(), NW);
        for (int k = 0; k < NW && k < beats.size(); k++)
            chk("bp_order", beats[k], 32'hA5000000 + 32'h111 * k);
        tick();

        // Asynchronous reset mid-frame at idx 4
        set_frame(32'h12340000, 32'd3);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("mr_idx4", bus.out_idx, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_in_ready", bus.in_ready, 1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("mr_no_replay", bus.out_valid, 0);
        set_frame(32'h55550000, 32'd2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("mr_restart_idx", bus.out_idx, 0);
        chk("mr_restart_word", bus.out, 32'h55550000);
        repeat (12) tick();

        // Back-to-back frames, in_valid held high
        set_frame(32'h3F800000, 32'd1);
        bus.in_valid = 1'b1;
        first_cyc = -1; last_cyc = -1; seen = 0; cyc = 0;
        while (seen < 2*NW && cyc < 60) begin
            tick();
            cyc++;
            if (bus.out_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                seen++;
                if (seen == 2*NW) begin
                    last_cyc = cyc;
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b_timeout", seen, 2*NW);
`ifdef P2S_BACK2BACK_EN
        chk("b2b_span", last_cyc - first_cyc + 1, 20);
`else
        chk("b2b_span", last_cyc - first_cyc + 1, 21);
`endif
        repeat (3) tick();

        // Loopback into the loader: weights 1.0 .. 10.0
        for (int k = 0; k < NW; k++) loader[k] = '0;
        for (int k = 0; k < NW; k++) bus.in_data[k*DW +: DW] = fp_tab[k];
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (11) tick();
        chk("lb_w0", loader[0], 32'h3F800000);
        chk("lb_w1", loader[1], 32'h40000000);
        chk("lb_w2", loader[2], 32'h40400000);
        chk("lb_w3", loader[3], 32'h40800000);
        chk("lb_w4", loader[4], 32'h40A00000);
        chk("lb_w5", loader[5], 32'h40C00000);
        chk("lb_w6", loader[6], 32'h40E00000);
        chk("lb_w7", loader[7], 32'h41000000);
        chk("lb_w8", loader[8], 32'h41100000);
        chk("lb_w9", loader[9], 32'h41200000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_parallel2serial_10i

// File: doc/parallel2serial_10i.md
Name: parallel2serial_10i

Overview:
- Frame serializer: accepts NUM_WORDS parallel DATA_WIDTH-bit words in one handshake and emits them one word per accepted beat on a single serial output, index 0 first.
- Counterpart of the serial weight loader. Its serial output drives the loader's word/load pair (out -> w, out_valid & out_ready -> load_weight). It is also used to stream perceptron-layer results out over one 32-bit bus.

Parameters:
- DATA_WIDTH, 32, width of each word (FP32).
- NUM_WORDS, 10, words per frame; must be >= 2.
- CNT_W, 4, index counter width; must satisfy 2**CNT_W >= NUM_WORDS.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  parallel frame present on in_data.
- in_ready  output  1  block can capture a frame this cycle.
- in_data  input  DATA_WIDTH*NUM_WORDS  frame; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out  output  DATA_WIDTH  current serial word.
- out_idx  output  CNT_W  index of the word on out.
- out_last  output  1  out holds word NUM_WORDS-1.
- busy  output  1  frame in progress (state SHIFT).

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, idx=0, frame register=0.
  - out_valid=0, out=0, out_idx=0, out_last=0, busy=0, in_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid (capture edge): load all NUM_WORDS words into the frame register, set idx=0, go to SHIFT.
  - out_valid rises the cycle after capture, so input-to-first-word latency is 1 cycle.
- SHIFT:
  - out = frame[idx], out_valid=1, out_idx=idx, out_last=(idx==NUM_WORDS-1).
  - On beat (out_valid & out_ready): idx++. If out_last, go to IDLE and set idx=0.
  - With no beat, out, out_idx and out_last are held stable; frame and idx are unchanged.
  - in_ready=0; in_valid is ignored and the frame register is never overwritten mid-frame.
- Throughput:
  - NUM_WORDS beats per frame when out_ready is held high.
  - 1 idle bubble between frames; the optional feature removes it.
- out holds its last value while out_valid=0; consumers must qualify with out_valid.
- rst asserted mid-frame aborts the frame immediately. The partial frame is discarded and nothing is replayed after reset releases.
- idx never exceeds NUM_WORDS-1. The unused counter encodes are unreachable; if one is reached, the next clock forces IDLE.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: P2S_BACK2BACK_EN.
- Defined:
  - in_ready = IDLE | (SHIFT & out_last & out_ready).
  - A capture coinciding with the last beat reloads the frame register, sets idx=0 and stays in SHIFT.
  - Frames stream with zero bubbles: N frames take N*NUM_WORDS cycles.
- Undefined: in_ready = IDLE only, as in Behaviour above; 1 bubble between frames.

Decomposition:
- Shared package/header p2s_defs: state encodings (IDLE=1'b0, SHIFT=1'b1) and the default DATA_WIDTH/NUM_WORDS/CNT_W constants, shared with the serial loader.
- One natural sub-module: p2s_word_mux (combinational frame/idx -> word select).
- The FSM, counter and frame register stay in the top.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst during SHIFT at idx=4.
  - Response: out_valid=0, busy=0, in_ready=1 in the same cycle (async); after release, the next frame starts at idx=0.
- Single frame, out_ready=1:
  - Stimulus: in_data words 0x3F800000+k, k=0..9.
  - Response: out_valid from capture+1 for 10 cycles; out=0x3F800000..0x3F800009 in order; out_last only on the 10th; busy falls after it.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles at idx=5.
  - Response: out=word5 and out_idx=5 held stable; no word skipped or duplicated.
  - Stimulus: a second in_valid pulse during SHIFT.
  - Response: in_ready=0, pulse ignored, serial output unchanged.
- Back-to-back frames, in_valid held high, out_ready=1:
  - Without P2S_BACK2BACK_EN: 21 cycles from the first out_valid to the last word of frame 2, including 1 bubble.
  - With P2S_BACK2BACK_EN: 20 cycles, no bubble.
- Loopback:
  - Stimulus: chain out/beat into the serial loader; send weights 1.0..10.0 (FP32).
  - Response: loader outputs word k=k+1.0 after the 10th beat.
